exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/RTE sequencer for the multicycle MIPS core.
- The main control unit hands over on an invalid opcode, ALU overflow or divide-by-zero.
- This block saves EPC, reads the handler byte address from memory vector 253/254/255, loads PC, then returns control with a done pulse. It also executes RTE (PC <= EPC).
- Its mux/write outputs are ORed/selected into the datapath controls while busy=1.

Parameters:
- MEM_WAIT, 3, memory read cycles before MDR captures data (matches fetch latency).
- VEC_OPCODE, 8'd253, vector address for invalid opcode.
- VEC_OVF, 8'd254, vector address for overflow.
- VEC_DIV0, 8'd255, vector address for divide-by-zero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- exc_start  in  1  one-cycle request from main control; causes sampled same cycle
- opcode_err  in  1  cause: invalid opcode/funct
- overflow_err  in  1  cause: ALU Overflow flag on addi/add/sub
- div0_err  in  1  cause: divisor zero
- rte_start  in  1  one-cycle RTE request
- busy  out  1  high while sequencing; main control must hold its write enables low
- done  out  1  one-cycle pulse when PC has been loaded
- cause_out  out  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 div0
- WriteEPC  out  1  EPC register write enable
- WritePC  out  1  PC write enable
- WriteMDR  out  1  memory data register write enable
- MemAddrCtrl  out  3  memory address mux: 3'b010 PC, 3'b011 exception vector
- ExcAddrSel  out  2  vector select (equals cause_out)
- ALUSrcACtrl  out  2  00 = PC
- ALUSrcBCtrl  out  3  001 = constant 4
- ALUCtrl  out  3  001 add, 010 sub
- PCSrcCtrl  out  2  01 = zero-extended MDR[7:0], 11 = EPC

Behaviour:
- All outputs are registered and Moore-decoded from the state.
- Reset (async) forces state IDLE, counter 0, cause_out 00, and all outputs 0 except MemAddrCtrl=3'b010. Reset mid-sequence aborts immediately; no partial PC write survives, but EPC may already hold its new value.
- States: IDLE, SAVE_EPC, READ_VEC, LOAD_PC, RTE_LOAD, DONE.
- IDLE:
  - exc_start=1 with any cause bit set: latch cause with priority opcode > overflow > div0, go to SAVE_EPC.
  - exc_start=1 with no cause bit set: ignored, stay IDLE.
  - rte_start=1 (and no valid exc_start): go to RTE_LOAD.
  - exc_start and rte_start together: exception wins; RTE is dropped.
- SAVE_EPC (1 cycle): ALUSrcA=00, ALUSrcB=001, ALUCtrl=010, WriteEPC=1, so EPC <= PC-4 (PC is already incremented by fetch). Next: READ_VEC, counter=0.
- READ_VEC (MEM_WAIT cycles): MemAddrCtrl=011, ExcAddrSel=cause_out. WriteMDR=1 only on the last cycle (counter==MEM_WAIT-1). Counter increments each cycle. Next: LOAD_PC.
- LOAD_PC (1 cycle): PCSrcCtrl=01, WritePC=1, so PC <= {24'b0, MDR[7:0]}. Next: DONE.
- RTE_LOAD (1 cycle): PCSrcCtrl=11, WritePC=1. Next: DONE. cause_out is unchanged.
- DONE (1 cycle): done=1, busy=0, all write enables 0. Next: IDLE.
- busy=1 in SAVE_EPC, READ_VEC, LOAD_PC and RTE_LOAD.
- Latency from exc_start edge to done: 2+MEM_WAIT+1 cycles (6 at default). RTE latency: 2 cycles.
- exc_start/rte_start while busy or in DONE: ignored (no queueing). The main control must not re-issue until done.
- cause_out holds until the next accepted exception; it feeds the Cause register.
- Counter width: clog2(MEM_WAIT)+1. MEM_WAIT=1 is legal (single READ_VEC cycle with WriteMDR=1).

Decomposition:
- Shared package ctrl_pkg holds:
  - state encoding for exc_ctrl;
  - cause codes;
  - MemAddrCtrl, ALUSrc, ALUCtrl and PCSrcCtrl encodings, shared with ctrl_unit so values never diverge;
  - vector address constants.
- One natural sub-module: exc_cause_enc, a 3-bit to 2-bit priority encoder for the causes.

Test Plan:
- Reset asserted mid-READ_VEC (counter=1) -> next edge state IDLE, busy=0, WriteMDR=0, MemAddrCtrl=010, cause_out=00.
- exc_start with overflow_err=1, PC=0x104, mem[254]=0x40 -> EPC=0x100 after cycle 1; WriteMDR on cycle 4; PC=0x40 after cycle 5; done on cycle 6; cause_out=10.
- exc_start with opcode_err=1 and div0_err=1 -> ExcAddrSel=01, vector 253 read, cause_out=01.
- rte_start with EPC=0x100 -> WritePC=1 with PCSrcCtrl=11 in cycle 1, done in cycle 2, PC=0x100, cause_out unchanged.
- exc_start=1 and rte_start=1 same cycle with div0_err=1 -> exception sequence runs (cause_out=11, vector 255); no RTE PC load occurs.
- exc_start re-pulsed during READ_VEC, and exc_start with all cause bits 0 in IDLE -> both ignored; latency and outputs identical to a single clean request.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: exception sequencer
// states, cause codes, datapath mux/ALU selects and exception vector addresses.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SAVE_EPC = 3'd1,
      S_READ_VEC = 3'd2,
      S_LOAD_PC  = 3'd3,
      S_RTE_LOAD = 3'd4,
      S_DONE     = 3'd5
   } exc_state_e;

   localparam logic [1:0] CAUSE_NONE   = 2'b00;
   localparam logic [1:0] CAUSE_OPCODE = 2'b01;
   localparam logic [1:0] CAUSE_OVF    = 2'b10;
   localparam logic [1:0] CAUSE_DIV0   = 2'b11;

   localparam logic [2:0] MEM_ADDR_PC  = 3'b010;
   localparam logic [2:0] MEM_ADDR_VEC = 3'b011;

   localparam logic [1:0] ALU_A_PC     = 2'b00;
   localparam logic [2:0] ALU_B_NONE   = 3'b000;
   localparam logic [2:0] ALU_B_FOUR   = 3'b001;

   localparam logic [2:0] ALU_NOP      = 3'b000;
   localparam logic [2:0] ALU_ADD      = 3'b001;
   localparam logic [2:0] ALU_SUB      = 3'b010;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_MDR    = 2'b01;
   localparam logic [1:0] PCSRC_EPC    = 2'b11;

   localparam logic [7:0] VEC_OPCODE   = 8'd253;
   localparam logic [7:0] VEC_OVF      = 8'd254;
   localparam logic [7:0] VEC_DIV0     = 8'd255;

   // Handler vector byte address for a latched cause.
   function automatic logic [7:0] cause_vec(input logic [1:0] cause);
      logic [7:0] v;
      case (cause)
         CAUSE_OPCODE: v = VEC_OPCODE;
         CAUSE_OVF:    v = VEC_OVF;
         CAUSE_DIV0:   v = VEC_DIV0;
         default:      v = 8'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/exc_cause_enc.sv
// Priority encoder for exception causes: opcode > overflow > divide-by-zero.
module exc_cause_enc
   import ctrl_pkg::*;
(
   input  logic       opcode_err,
   input  logic       overflow_err,
   input  logic       div0_err,
   output logic [1:0] cause,
   output logic       valid
);

   // Highest-priority asserted cause wins.
   always_comb begin
      cause = CAUSE_NONE;
      valid = 1'b1;
      if (opcode_err) begin
         cause = CAUSE_OPCODE;
      end else if (overflow_err) begin
         cause = CAUSE_OVF;
      end else if (div0_err) begin
         cause = CAUSE_DIV0;
      end else begin
         valid = 1'b0;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception / RTE sequencer: saves EPC, fetches the handler vector, loads PC.
// Outputs are registered, decoded from the next state so they align with it.
module exc_ctrl
   import ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       exc_start,
   input  logic       opcode_err,
   input  logic       overflow_err,
   input  logic       div0_err,
   input  logic       rte_start,
   output logic       busy,
   output logic       done,
   output logic [1:0] cause_out,
   output logic       WriteEPC,
   output logic       WritePC,
   output logic       WriteMDR,
   output logic [2:0] MemAddrCtrl,
   output logic [1:0] ExcAddrSel,
   output logic [1:0] ALUSrcACtrl,
   output logic [2:0] ALUSrcBCtrl,
   output logic [2:0] ALUCtrl,
   output logic [1:0] PCSrcCtrl
);

   localparam int CW = $clog2(MEM_WAIT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT - 1);

   exc_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    cause_q, cause_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          write_epc_q, write_epc_d;
   logic          write_pc_q, write_pc_d;
   logic          write_mdr_q, write_mdr_d;
   logic [2:0]    mem_addr_q, mem_addr_d;
   logic [1:0]    alu_a_q, alu_a_d;
   logic [2:0]    alu_b_q, alu_b_d;
   logic [2:0]    alu_op_q, alu_op_d;
   logic [1:0]    pc_src_q, pc_src_d;

   logic [1:0]    enc_cause_s;
   logic          enc_valid_s;

   exc_cause_enc u_cause_enc (
      .opcode_err   (opcode_err),
      .overflow_err (overflow_err),
      .div0_err     (div0_err),
      .cause        (enc_cause_s),
      .valid        (enc_valid_s)
   );

   // Next-state, counter and cause latch; requests outside IDLE are dropped.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      case (state_q)
         S_IDLE: begin
            if (exc_start && enc_valid_s) begin
               cause_d = enc_cause_s;
               state_d = S_SAVE_EPC;
            end else if (rte_start) begin
               state_d = S_RTE_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SAVE_EPC: begin
            state_d = S_READ_VEC;
            cnt_d   = {CW{1'b0}};
         end
         S_READ_VEC: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_LOAD_PC;
            end else begin
               state_d = S_READ_VEC;
            end
         end
         S_LOAD_PC:  state_d = S_DONE;
         S_RTE_LOAD: state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            cnt_d   = {CW{1'b0}};
         end
      endcase
   end

   // Moore decode of the upcoming state into the datapath controls.
   always_comb begin
      busy_d      = 1'b0;
      done_d      = 1'b0;
      write_epc_d = 1'b0;
      write_pc_d  = 1'b0;
      write_mdr_d = 1'b0;
      mem_addr_d  = MEM_ADDR_PC;
      alu_a_d     = ALU_A_PC;
      alu_b_d     = ALU_B_NONE;
      alu_op_d    = ALU_NOP;
      pc_src_d    = PCSRC_ALU;
      case (state_d)
         S_IDLE: begin
            busy_d = 1'b0;
         end
         S_SAVE_EPC: begin
            busy_d      = 1'b1;
            write_epc_d = 1'b1;
            alu_a_d     = ALU_A_PC;
            alu_b_d     = ALU_B_FOUR;
            alu_op_d    = ALU_SUB;
         end
         S_READ_VEC: begin
            busy_d      = 1'b1;
            mem_addr_d  = MEM_ADDR_VEC;
            write_mdr_d = (cnt_d == CNT_LAST);
         end
         S_LOAD_PC: begin
            busy_d     = 1'b1;
            write_pc_d = 1'b1;
            pc_src_d   = PCSRC_MDR;
         end
         S_RTE_LOAD: begin
            busy_d     = 1'b1;
            write_pc_d = 1'b1;
            pc_src_d   = PCSRC_EPC;
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // State, counter, cause and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= {CW{1'b0}};
         cause_q     <= CAUSE_NONE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         write_epc_q <= 1'b0;
         write_pc_q  <= 1'b0;
         write_mdr_q <= 1'b0;
         mem_addr_q  <= MEM_ADDR_PC;
         alu_a_q     <= 2'b00;
         alu_b_q     <= 3'b000;
         alu_op_q    <= 3'b000;
         pc_src_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cause_q     <= cause_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         write_epc_q <= write_epc_d;
         write_pc_q  <= write_pc_d;
         write_mdr_q <= write_mdr_d;
         mem_addr_q  <= mem_addr_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         pc_src_q    <= pc_src_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign cause_out   = cause_q;
   assign ExcAddrSel  = cause_q;
   assign WriteEPC    = write_epc_q;
   assign WritePC     = write_pc_q;
   assign WriteMDR    = write_mdr_q;
   assign MemAddrCtrl = mem_addr_q;
   assign ALUSrcACtrl = alu_a_q;
   assign ALUSrcBCtrl = alu_b_q;
   assign ALUCtrl     = alu_op_q;
   assign PCSrcCtrl   = pc_src_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl with a tiny PC/EPC/MDR datapath model.
module tb_exc_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic exc_start, opcode_err, overflow_err, div0_err, rte_start;
   logic busy, done, WriteEPC, WritePC, WriteMDR;
   logic [1:0] cause_out, ExcAddrSel, ALUSrcACtrl, PCSrcCtrl;
   logic [2:0] MemAddrCtrl, ALUSrcBCtrl, ALUCtrl;

   logic exc1, op1, ovf1, d01, rte1;
   logic busy1, done1, wepc1, wpc1, wmdr1;
   logic [1:0] cause1, sel1, a1, ps1;
   logic [2:0] mac1, b1, alu1;

   exc_ctrl #(.MEM_WAIT(3)) u_dut (
      .clk(clk), .reset(rst), .exc_start(exc_start), .opcode_err(opcode_err),
      .overflow_err(overflow_err), .div0_err(div0_err), .rte_start(rte_start),
      .busy(busy), .done(done), .cause_out(cause_out), .WriteEPC(WriteEPC),
      .WritePC(WritePC), .WriteMDR(WriteMDR), .MemAddrCtrl(MemAddrCtrl),
      .ExcAddrSel(ExcAddrSel), .ALUSrcACtrl(ALUSrcACtrl), .ALUSrcBCtrl(ALUSrcBCtrl),
      .ALUCtrl(ALUCtrl), .PCSrcCtrl(PCSrcCtrl)
   );

   exc_ctrl #(.MEM_WAIT(1)) u_dut1 (
      .clk(clk), .reset(rst), .exc_start(exc1), .opcode_err(op1),
      .overflow_err(ovf1), .div0_err(d01), .rte_start(rte1),
      .busy(busy1), .done(done1), .cause_out(cause1), .WriteEPC(wepc1),
      .WritePC(wpc1), .WriteMDR(wmdr1), .MemAddrCtrl(mac1),
      .ExcAddrSel(sel1), .ALUSrcACtrl(a1), .ALUSrcBCtrl(b1),
      .ALUCtrl(alu1), .PCSrcCtrl(ps1)
   );

   // Datapath model reacting to the control outputs.
   logic [31:0] pc_m = 32'h0;
   logic [31:0] epc_m = 32'h0;
   logic [31:0] mdr_m = 32'h0;
   logic [31:0] pc_init = 32'h0;
   logic        pc_load = 1'b0;

   function automatic logic [7:0] mem_rd(input logic [7:0] addr);
      case (addr)
         8'd253:  return 8'h20;
         8'd254:  return 8'h40;
         8'd255:  return 8'h60;
         default: return 8'hEE;
      endcase
   endfunction

   always @(posedge clk) begin
      if (pc_load) pc_m <= pc_init;
      else if (WritePC) pc_m <= (PCSrcCtrl == 2'b01) ? {24'h0, mdr_m[7:0]} :
                               (PCSrcCtrl == 2'b11) ? epc_m : 32'hDEAD_BEEF;
      if (WriteEPC)
         epc_m <= (ALUSrcACtrl == 2'b00 && ALUSrcBCtrl == 3'b001 && ALUCtrl == 3'b010) ?
                  pc_m - 32'd4 : 32'hBAD0_BAD0;
      if (WriteMDR)
         mdr_m <= (MemAddrCtrl == 3'b011) ? {24'h0, mem_rd(8'd252 + {6'b0, ExcAddrSel})} : 32'h0000_0BAD;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] obs();
      return {busy, done, WriteEPC, WriteMDR, WritePC, MemAddrCtrl, PCSrcCtrl,
              ALUSrcACtrl, ALUSrcBCtrl, ALUCtrl};
   endfunction

   // Expected control word in cycle k of a sequence with latency lat (6 exc, 2 rte, 0 none).
   function automatic logic [17:0] exp_ctrl(input int lat, input int k);
      logic b, d, we, wm, wp;
      logic [2:0] mac, bb, alu;
      logic [1:0] ps;
      b   = (lat == 6) ? (k <= 5) : (lat == 2) ? (k == 1) : 1'b0;
      d   = (lat != 0) && (k == lat);
      we  = (lat == 6) && (k == 1);
      wm  = (lat == 6) && (k == 4);
      wp  = ((lat == 6) && (k == 5)) || ((lat == 2) && (k == 1));
      mac = ((lat == 6) && k >= 2 && k <= 4) ? 3'b011 : 3'b010;
      ps  = ((lat == 6) && (k == 5)) ? 2'b01 : ((lat == 2) && (k == 1)) ? 2'b11 : 2'b00;
      bb  = we ? 3'b001 : 3'b000;
      alu = we ? 3'b010 : 3'b000;
      return {b, d, we, wm, wp, mac, ps, 2'b00, bb, alu};
   endfunction

   typedef struct {
      logic        exc, op, ovf, d0, rte, repulse;
      logic [31:0] pc_in;
      logic [1:0]  exp_cause;
      int          exp_lat;
      logic [31:0] exp_pc, exp_epc;
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input int i);
      vec_t v;
      int   lat;
      v = vecs[i];
      @(negedge clk);
      pc_init = v.pc_in;
      pc_load = 1'b1;
      @(negedge clk);
      pc_load = 1'b0;
      exc_start = v.exc; opcode_err = v.op; overflow_err = v.ovf;
      div0_err = v.d0; rte_start = v.rte;
      @(negedge clk);
      exc_start = 1'b0; opcode_err = 1'b0; overflow_err = 1'b0;
      div0_err = 1'b0; rte_start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         chk($sformatf("v%0d_c%0d_ctrl", i, k), {14'h0, obs()}, {14'h0, exp_ctrl(v.exp_lat, k)});
         if (v.exp_lat == 6 && k >= 2 && k <= 4)
            chk($sformatf("v%0d_c%0d_excaddrsel", i, k), {30'h0, ExcAddrSel}, {30'h0, v.exp_cause});
         if (done && lat == 0) lat = k;
         if (v.repulse && k == 3) begin
            exc_start = 1'b1; opcode_err = 1'b1;
         end else begin
            exc_start = 1'b0; opcode_err = 1'b0;
         end
         @(negedge clk);
      end
      chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
      chk($sformatf("v%0d_cause", i), {30'h0, cause_out}, {30'h0, v.exp_cause});
      chk($sformatf("v%0d_pc", i), pc_m, v.exp_pc);
      chk($sformatf("v%0d_epc", i), epc_m, v.exp_epc);
   endtask

   initial begin
      logic [3:0] exp1 [1:5];
      vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 2'b10, 6, 32'h40, 32'h100};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h208, 2'b01, 6, 32'h20, 32'h204};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 2'b01, 2, 32'h204, 32'h204};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h034, 2'b11, 6, 32'h60, 32'h030};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h700, 2'b11, 0, 32'h700, 32'h030};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h088, 2'b10, 6, 32'h40, 32'h084};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h010, 2'b01, 6, 32'h20, 32'h00C};
      exp1[1] = 4'b1000; exp1[2] = 4'b0100; exp1[3] = 4'b0010; exp1[4] = 4'b0001; exp1[5] = 4'b0000;

      rst = 1'b1;
      exc_start = 1'b0; opcode_err = 1'b0; overflow_err = 1'b0; div0_err = 1'b0; rte_start = 1'b0;
      exc1 = 1'b0; op1 = 1'b0; ovf1 = 1'b0; d01 = 1'b0; rte1 = 1'b0;
      #2;
      chk("reset_ctrl", {14'h0, obs()}, {14'h0, exp_ctrl(0, 1)});
      chk("reset_cause", {30'h0, cause_out}, 32'h0);
      chk("reset_excaddrsel", {30'h0, ExcAddrSel}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(i);

      // Asynchronous reset in the middle of READ_VEC (counter = 1).
      @(negedge clk);
      exc_start = 1'b1; overflow_err = 1'b1;
      @(negedge clk);
      exc_start = 1'b0; overflow_err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_pre_memaddr", {29'h0, MemAddrCtrl}, 32'h3);
      rst = 1'b1;
      #1;
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      chk("midrst_wmdr", {31'h0, WriteMDR}, 32'h0);
      chk("midrst_memaddr", {29'h0, MemAddrCtrl}, 32'h2);
      chk("midrst_cause", {30'h0, cause_out}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("midrst_idle_%0d", k), {14'h0, obs()}, {14'h0, exp_ctrl(0, 1)});
      end

      // Single-cycle vector read with MEM_WAIT = 1.
      @(negedge clk);
      exc1 = 1'b1; d01 = 1'b1;
      @(negedge clk);
      exc1 = 1'b0; d01 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("mw1_c%0d", k), {28'h0, wepc1, wmdr1, wpc1, done1}, {28'h0, exp1[k]});
         if (k == 2) chk("mw1_memaddr", {29'h0, mac1}, 32'h3);
         @(negedge clk);
      end
      chk("mw1_cause", {30'h0, cause1}, 32'h3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
